if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator that drives the instruction ROM's chip-enable/address port and receives the returned word.
- Holds the PC and advances it by 4 per fetch.
- Buffers fetched {pc, inst} pairs in a small queue and presents them to the ID stage over a valid/ready handshake.
- Accepts branch/jump redirects, which flush in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- QUEUE_DEPTH, 2, fetch queue entries; power of two, range 2..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- redirect_valid  in  1  branch/jump taken; kill younger fetches.
- redirect_pc  in  `InstAddrBus  redirect target.
- id_ready  in  1  ID stage accepts the head entry this cycle.
- rom_ce  out  1  ROM chip enable (`ChipEnable / `ChipDisable).
- rom_addr  out  `InstAddrBus  ROM byte address (= pc).
- rom_inst  in  `InstBus  ROM data; combinational, same cycle, already in instruction byte order.
- if_valid  out  1  head entry valid.
- if_pc  out  `InstAddrBus  head entry PC.
- if_inst  out  `InstBus  head entry instruction.
- if_misalign  out  1  present only with IF_MISALIGN_TRAP_EN; head entry carries a misaligned-target fault.

Behaviour:
- Reset (rst=0 at posedge):
  - pc <= RESET_PC; queue emptied; run flag <= 0.
  - rom_ce = `ChipDisable; rom_addr = pc; if_valid = 0; if_pc = 0; if_inst = `ZeroWord.
- Start-up: the first cycle after reset releases is a dead cycle (run flag sets). Fetching begins the following cycle, so the first rom_ce=1 occurs 2 cycles after rst rises.
- States:
  - IDLE: reset, and the first cycle after it.
  - RUN: fetching.
  - HALT: only with IF_MISALIGN_TRAP_EN.
  - Transitions: IDLE->RUN unconditionally; RUN->HALT on misaligned redirect (macro only); HALT->RUN on an aligned redirect.
- Fetch enable: rom_ce = RUN & !redirect_valid & (count < QUEUE_DEPTH | deq), where deq = if_valid & id_ready.
- Fetch cycle (rom_ce=1): enqueue {pc, rom_inst} at the tail; pc <= pc + 4. PC wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- Output: head entry presented from registered queue storage. No combinational path from rom_inst to the if_* outputs.
- Fetch-to-ID latency: 1 cycle.
- Full queue without deq: no fetch, PC holds, rom_ce=0.
- Full queue with deq in the same cycle: fetch and enqueue allowed; count unchanged.
- Empty queue: if_valid=0; if_pc and if_inst hold their last values; id_ready ignored.
- Redirect cycle (redirect_valid=1):
  - Queue flushed at the clock edge; pc <= {redirect_pc[31:2], 2'b00}; no fetch.
  - if_valid forced to 0 combinationally, so no handshake completes this cycle.
  - The next cycle fetches the target; the target appears on if_valid one cycle later.
- Back-to-back redirects: the last one wins; each cycle behaves as a redirect cycle.
- Redirect while in IDLE: pc is updated; start-up timing is unchanged.
- Reset mid-operation: reset overrides everything, including a concurrent redirect.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Without it: redirect_pc[1:0] is silently forced to 00; there is no if_misalign port and no HALT state.
- With it, a redirect where redirect_pc[1:0] != 0:
  - Flushes the queue and enqueues one fault entry: pc=redirect_pc unmodified, inst=`ZeroWord, if_misalign=1.
  - Enters HALT: rom_ce=0, no further fetches.
  - An aligned redirect returns the block to RUN.
- Normal entries carry if_misalign=0.

Decomposition:
- Shared defines header supplies `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, `ChipDisable, and a new `RstEnable = 1'b0.
- Fetch state encodings (IDLE/RUN/HALT) are also added to the shared defines header.
- Sub-module fetch_queue: generic synchronous FIFO (WIDTH, DEPTH, enq, deq, flush, full, empty, head). The fetch logic instantiates it with WIDTH=64, or 65 with the macro.

Test Plan:
- Reset release, id_ready=1 -> first rom_ce=1 with rom_addr=0 on cycle 2; if_pc sequence 0,4,8,… one per cycle; if_inst equals the ROM word at each address.
- id_ready=0 for 5 cycles after 3 fetches -> exactly 2 entries buffered, rom_ce=0, pc holds at 8; on release, pcs 0 and 4 are delivered first with no duplicates or gaps.
- redirect_pc=32'h100 while queue full -> if_valid=0 that cycle, no old entries emerge, next if_pc=32'h100 two cycles later.
- redirect_pc=32'h102 -> without macro, if_pc=32'h100; with macro, if_pc=32'h102, if_misalign=1, if_inst=0, rom_ce stays 0 until redirect_pc=32'h200 is applied.
- RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst=0 asserted mid-stream with redirect_valid=1 -> next cycle queue empty, pc=RESET_PC, rom_ce=0, if_valid=0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction-fetch block.
//   - Bus-width / constant macros (`InstAddrBus, `InstBus, `ZeroWord,
//     `ChipEnable, `ChipDisable, `RstEnable) and fetch state encodings.
//   - fetch_state_e : fetch FSM state type (IDLE / RUN / HALT).
//   - fetch_entry_t : one fetch-queue entry {pc, inst}; with
//     IF_MISALIGN_TRAP_EN defined it also carries a misalign flag.
//   - next_pc()     : sequential PC increment (wraps mod 2^32).
//   Configuration macro: IF_MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
`ifndef IF_FETCH_DEFINES_SVH
`define IF_FETCH_DEFINES_SVH
`define InstAddrBus 31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define RstEnable   1'b0
`define FETCH_IDLE  2'b00
`define FETCH_RUN   2'b01
`define FETCH_HALT  2'b10
`endif

package if_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `FETCH_IDLE,
        ST_RUN  = `FETCH_RUN,
        ST_HALT = `FETCH_HALT
    } fetch_state_e;

    typedef struct packed {
`ifdef IF_MISALIGN_TRAP_EN
        logic              misalign;
`endif
        logic [`InstAddrBus] pc;
        logic [`InstBus]     inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Generic synchronous FIFO used as the fetch queue.
//   Parameters: WIDTH (entry bits), DEPTH (entries, power of two).
//   Ports:
//     clk, rst      clock, synchronous active-low reset (empties the FIFO)
//     flush         discard all entries at the clock edge
//     enq, enq_data write enq_data at the tail (also allowed with flush:
//                   the written entry becomes the only entry)
//     deq           drop the head entry (caller only asserts when !empty)
//     full, empty   occupancy flags
//     head          entry at the read pointer (registered storage)
//   Caller contract: enq only when !full, or when deq is asserted in the
//   same cycle (count then stays unchanged).
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_idx;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        // A flush restarts both pointers at slot 0, so an entry written in
        // the flush cycle lands in slot 0 and becomes the new head.
        wr_idx = flush ? '0 : wr_ptr_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = enq ? AW'(1) : '0;
            count_d  = enq ? CW'(1) : '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(deq);
            wr_ptr_d = wr_ptr_q + AW'(enq);
            count_d  = count_q + CW'(enq) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count_q is non-zero.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[wr_idx] <= enq_data;
        end
    end

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch initiator. Drives the instruction ROM (rom_ce /
//   rom_addr), captures the returned word together with its PC into a small
//   queue and presents the head entry to the ID stage.
//
//   Handshake: an entry transfers to ID in a cycle where if_valid and
//   id_ready are both 1 at the rising clk edge. if_valid never depends on
//   id_ready; id_ready is ignored while if_valid is 0.
//
//   Parameters:
//     RESET_PC     PC loaded on reset
//     QUEUE_DEPTH  fetch queue entries (power of two, 2..8)
//   Ports:
//     clk, rst          clock, synchronous active-low reset
//     redirect_valid    branch/jump taken: flush queue, load redirect_pc
//     redirect_pc       redirect target
//     id_ready          ID accepts the head entry this cycle
//     rom_ce, rom_addr  ROM request (address = current pc)
//     rom_inst          ROM data, valid in the same cycle as the request
//     if_valid/if_pc/if_inst  head entry towards ID
//     if_misalign       head entry is a misaligned-target fault
//                       (only with IF_MISALIGN_TRAP_EN)
//     dbg_state         current fetch FSM state
//   Configuration macro: IF_MISALIGN_TRAP_EN (misaligned redirect trap).
// ---------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [`InstAddrBus] redirect_pc,
    input  logic                id_ready,
    output logic                rom_ce,
    output logic [`InstAddrBus] rom_addr,
    input  logic [`InstBus]     rom_inst,
    output logic                if_valid,
    output logic [`InstAddrBus] if_pc,
    output logic [`InstBus]     if_inst,
`ifdef IF_MISALIGN_TRAP_EN
    output logic                if_misalign,
`endif
    output fetch_state_e        dbg_state
);

    fetch_state_e        state_q, state_d;
    logic [`InstAddrBus] pc_q, pc_d;
    // Last entry handed to ID; shown while the queue is empty.
    logic [`InstAddrBus] hold_pc_q, hold_pc_d;
    logic [`InstBus]     hold_inst_q, hold_inst_d;

    logic         q_full, q_empty;
    logic         q_enq, q_deq;
    fetch_entry_t q_enq_data, q_head;
    logic         fetch_en;
    logic         redirect_misalign;

`ifdef IF_MISALIGN_TRAP_EN
    assign redirect_misalign = redirect_valid & (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_misalign = 1'b0;
`endif

    // A redirect hides the head combinationally so no stale entry can be
    // accepted in the cycle it is being flushed.
    assign if_valid = ~q_empty & ~redirect_valid;
    assign q_deq    = if_valid & id_ready;

    // Fetch only while running, not while redirecting, and only if there is
    // room now or the head leaves in this same cycle.
    assign fetch_en = (state_q == ST_RUN) & ~redirect_valid & (~q_full | q_deq);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        q_enq       = 1'b0;

        q_enq_data      = '0;
        q_enq_data.pc   = pc_q;
        q_enq_data.inst = rom_inst;

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            // Low address bits are dropped; the trap build checks them first.
            pc_d = redirect_pc & 32'hFFFF_FFFC;
            if (redirect_misalign) begin
                // Fault entry: untouched target, zero instruction word.
                state_d         = ST_HALT;
                q_enq           = 1'b1;
                q_enq_data.pc   = redirect_pc;
                q_enq_data.inst = `ZeroWord;
`ifdef IF_MISALIGN_TRAP_EN
                q_enq_data.misalign = 1'b1;
`endif
            end else if (state_q == ST_HALT) begin
                state_d = ST_RUN;
            end
        end else if (fetch_en) begin
            q_enq = 1'b1;
            pc_d  = next_pc(pc_q);
        end

        if (q_deq) begin
            hold_pc_d   = q_head.pc;
            hold_inst_d = q_head.inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            hold_pc_q   <= '0;
            hold_inst_q <= `ZeroWord;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    if_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .enq      (q_enq),
        .enq_data (q_enq_data),
        .deq      (q_deq),
        .full     (q_full),
        .empty    (q_empty),
        .head     (q_head)
    );

    assign rom_ce    = fetch_en ? `ChipEnable : `ChipDisable;
    assign rom_addr  = pc_q;
    assign if_pc     = q_empty ? hold_pc_q   : q_head.pc;
    assign if_inst   = q_empty ? hold_inst_q : q_head.inst;
    assign dbg_state = state_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign if_misalign = ~q_empty & q_head.misalign;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch. Stimulus pushes the expected {misalign,
//   pc, inst} of each entry ID should receive into exp_q; a monitor pops and
//   compares on every completed handshake. A second instance checks the
//   RESET_PC wrap case.
// ---------------------------------------------------------------------------
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk;
    logic        rst, redirect_valid, id_ready;
    logic [31:0] redirect_pc;
    logic        rom_ce, if_valid;
    logic [31:0] rom_addr, rom_inst, if_pc, if_inst;
    fetch_state_e dbg_state;

    logic        rst2, redirect_valid2, id_ready2;
    logic [31:0] redirect_pc2;
    logic        rom_ce2, if_valid2;
    logic [31:0] rom_addr2, rom_inst2, if_pc2, if_inst2;
    fetch_state_e dbg_state2;
`ifdef IF_MISALIGN_TRAP_EN
    logic        if_misalign, if_misalign2;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] exp2_q[$];

    // ---------------- ROM model ----------------
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A0F};
    endfunction

    function automatic logic [64:0] mk(input logic [31:0] pc);
        return {1'b0, pc, rom_word(pc)};
    endfunction

    assign rom_inst  = rom_word(rom_addr);
    assign rom_inst2 = rom_word(rom_addr2);

    // ---------------- DUTs ----------------
    if_fetch #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready),
        .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
`ifdef IF_MISALIGN_TRAP_EN
        .if_misalign(if_misalign),
`endif
        .dbg_state(dbg_state)
    );

    if_fetch #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst2), .redirect_valid(redirect_valid2),
        .redirect_pc(redirect_pc2), .id_ready(id_ready2),
        .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_inst(if_inst2),
`ifdef IF_MISALIGN_TRAP_EN
        .if_misalign(if_misalign2),
`endif
        .dbg_state(dbg_state2)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 65'(exp_q.size()), 65'd0);
        exp_q.delete();
        id_ready = 1'b0;
    endtask

    task automatic drain2(input string name);
        int n = 0;
        while (exp2_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 65'(exp2_q.size()), 65'd0);
        exp2_q.delete();
        id_ready2 = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [64:0] e;
        if (if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got pc %h, expected no entry", if_pc);
            end else begin
                e = exp_q.pop_front();
                check("head_pc", 65'(if_pc), 65'(e[63:32]));
                check("head_inst", 65'(if_inst), 65'(e[31:0]));
`ifdef IF_MISALIGN_TRAP_EN
                check("head_misalign", 65'(if_misalign), 65'(e[64]));
`endif
            end
        end
        if (if_valid2 && id_ready2) begin
            if (exp2_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry2: got pc %h, expected no entry", if_pc2);
            end else begin
                e = exp2_q.pop_front();
                check("head2_pc", 65'(if_pc2), 65'(e[63:32]));
                check("head2_inst", 65'(if_inst2), 65'(e[31:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        rst2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0; id_ready2 = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_rom_ce", 65'(rom_ce), 65'd0);
        check("rst_rom_addr", 65'(rom_addr), 65'h0);
        check("rst_if_valid", 65'(if_valid), 65'd0);
        check("rst_if_pc", 65'(if_pc), 65'h0);
        check("rst_if_inst", 65'(if_inst), 65'h0);
        check("rst_state", 65'(dbg_state), 65'(ST_IDLE));
        check("rst2_rom_addr", 65'(rom_addr2), 65'hFFFF_FFF8);
        check("rst2_state", 65'(dbg_state2), 65'(ST_IDLE));

        // Start-up: dead cycle, then sequential stream 0,4,8,...
        rst = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(i * 4)));
        #1;
        check("dead_rom_ce", 65'(rom_ce), 65'd0);
        tick();
        check("first_rom_ce", 65'(rom_ce), 65'd1);
        check("first_rom_addr", 65'(rom_addr), 65'h0);
        check("first_if_valid", 65'(if_valid), 65'd0);
        drain("seq");

        // Back-pressure: queue fills to 2 entries, pc holds at 8
        rst = 1'b0;
        tick();
        rst = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_rom_ce", 65'(rom_ce), 65'd0);
            check("stall_rom_addr", 65'(rom_addr), 65'h8);
            check("stall_if_valid", 65'(if_valid), 65'd1);
            check("stall_if_pc", 65'(if_pc), 65'h0);
        end
        for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(i * 4)));
        id_ready = 1'b1;
        drain("stall");

        // Redirect while full
        repeat (3) tick();
        check("full_rom_ce", 65'(rom_ce), 65'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        id_ready = 1'b1;
        exp_q.push_back(mk(32'h100));
        exp_q.push_back(mk(32'h104));
        exp_q.push_back(mk(32'h108));
        #1;
        check("redir_if_valid", 65'(if_valid), 65'd0);
        check("redir_rom_ce", 65'(rom_ce), 65'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir_next_rom_ce", 65'(rom_ce), 65'd1);
        check("redir_next_rom_addr", 65'(rom_addr), 65'h100);
        check("redir_next_if_valid", 65'(if_valid), 65'd0);
        tick();
        check("redir_target_valid", 65'(if_valid), 65'd1);
        check("redir_target_pc", 65'(if_pc), 65'h100);
        drain("redirect");

        // Misaligned redirect
        repeat (2) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        id_ready = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
        exp_q.push_back({1'b1, 32'h102, 32'h0});
        tick();
        redirect_valid = 1'b0;
        #1;
        check("trap_rom_ce", 65'(rom_ce), 65'd0);
        check("trap_if_valid", 65'(if_valid), 65'd1);
        check("trap_if_pc", 65'(if_pc), 65'h102);
        check("trap_if_inst", 65'(if_inst), 65'h0);
        check("trap_if_misalign", 65'(if_misalign), 65'd1);
        tick();
        check("halt_rom_ce", 65'(rom_ce), 65'd0);
        check("halt_if_valid", 65'(if_valid), 65'd0);
        tick();
        check("halt_rom_ce2", 65'(rom_ce), 65'd0);
        check("halt_state", 65'(dbg_state), 65'(ST_HALT));
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        exp_q.push_back(mk(32'h200));
        exp_q.push_back(mk(32'h204));
        tick();
        redirect_valid = 1'b0;
        #1;
        check("resume_rom_ce", 65'(rom_ce), 65'd1);
        check("resume_rom_addr", 65'(rom_addr), 65'h200);
`else
        exp_q.push_back(mk(32'h100));
        exp_q.push_back(mk(32'h104));
        tick();
        redirect_valid = 1'b0;
        #1;
        check("align_rom_ce", 65'(rom_ce), 65'd1);
        check("align_rom_addr", 65'(rom_addr), 65'h100);
`endif
        drain("misalign");

        // Reset mid-stream together with a redirect
        repeat (3) tick();
        rst = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        id_ready = 1'b1;
        #1;
        check("rst_redir_if_valid", 65'(if_valid), 65'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("midrst_if_valid", 65'(if_valid), 65'd0);
        check("midrst_rom_ce", 65'(rom_ce), 65'd0);
        check("midrst_rom_addr", 65'(rom_addr), 65'h0);
        check("midrst_if_pc", 65'(if_pc), 65'h0);
        check("midrst_state", 65'(dbg_state), 65'(ST_IDLE));
        rst = 1'b1;
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h8));
        tick();
        check("restart_rom_ce", 65'(rom_ce), 65'd1);
        check("restart_rom_addr", 65'(rom_addr), 65'h0);
        drain("restart");

        // PC wrap on the second instance
        id_ready2 = 1'b1;
        exp2_q.push_back(mk(32'hFFFF_FFF8));
        exp2_q.push_back(mk(32'hFFFF_FFFC));
        exp2_q.push_back(mk(32'h0000_0000));
        exp2_q.push_back(mk(32'h0000_0004));
        rst2 = 1'b1;
        tick();
        check("wrap_first_addr", 65'(rom_addr2), 65'hFFFF_FFF8);
        drain2("wrap");

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
